// File: rtl/cgra_pkg.sv
// Shared definitions for the reconfigurable cell: opcodes, instruction layout
// and derived field widths.
package cgra_pkg;

  localparam int N_NEIGH_DEF = 4;
  localparam int SEL_W       = $clog2(N_NEIGH_DEF + 3);
  localparam int IMM_W       = 16;
  localparam int INSTR_W     = 4 + 2 * SEL_W + IMM_W;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_LOAD  = 4'd8,
    OP_STORE = 4'd9,
    OP_BRZ   = 4'd10,
    OP_EXIT  = 4'd11
  } op_e;

  // op kept as raw bits so undefined encodings survive and decode as NOP
  typedef struct packed {
    logic [3:0]       op;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [IMM_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/rc_ctx_conf_regs.sv
// Per-context instruction store: N_CTX x N_CREG slots, one write port and one
// combinational read port. Reset clears every slot to NOP.
module rc_ctx_conf_regs
  import cgra_pkg::*;
#(
  parameter int N_CTX  = 2,
  parameter int N_CREG = 16,
  parameter int CTX_W  = 1,
  parameter int PC_W   = 4
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             we,
  input  logic [CTX_W-1:0] wctx,
  input  logic [PC_W-1:0]  waddr,
  input  instr_t           wdata,
  input  logic [CTX_W-1:0] rctx,
  input  logic [PC_W-1:0]  raddr,
  output instr_t           rdata
);

  instr_t slots [N_CTX][N_CREG];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int c = 0; c < N_CTX; c++)
        for (int s = 0; s < N_CREG; s++)
          slots[c][s] <= '0;
    end else if (we) begin
      slots[wctx][waddr] <= wdata;
    end
  end

  assign rdata = slots[rctx][raddr];

endmodule

// File: rtl/reconfigurable_cell_mc.sv
// Multi-context CGRA cell: executes the slot selected by the array PC from the
// active context, with a blocking load/store port and a branch request output.
module reconfigurable_cell_mc
  import cgra_pkg::*;
#(
  parameter  int DP_WIDTH = 32,
  parameter  int N_NEIGH  = 4,
  parameter  int N_CREG   = 16,
  parameter  int N_CTX    = 2,
  localparam int CTX_W    = (N_CTX > 1) ? $clog2(N_CTX) : 1,
  localparam int PC_W     = (N_CREG > 1) ? $clog2(N_CREG) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  conf_we_i,
  input  logic [CTX_W-1:0]      conf_wctx_i,
  input  logic [PC_W-1:0]       conf_waddr_i,
  input  logic [INSTR_W-1:0]    conf_wdata_i,
  input  logic [CTX_W-1:0]      ctx_sel_i,
  input  logic                  start_i,
  input  logic                  pc_en_i,
  input  logic [PC_W-1:0]       global_pc_i,
  input  logic [N_NEIGH*DP_WIDTH-1:0] neigh_res_i,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [DP_WIDTH-1:0]   data_rdata_i,
  output logic [DP_WIDTH-1:0]   result_o,
  output logic [1:0]            flag_o,
  output logic                  br_req_o,
  output logic [PC_W-1:0]       br_add_o,
  output logic                  data_req_o,
  output logic                  data_wen_o,
  output logic [DP_WIDTH-1:0]   data_add_o,
  output logic [DP_WIDTH-1:0]   data_wdata_o,
  output logic                  rc_stall_o,
  output logic                  busy_o,
  output logic                  conf_err_o,
  output logic                  exec_end_o
);

  localparam int SH_W = $clog2(DP_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM_REQ, S_MEM_WAIT} state_e;

  state_e              state, state_nxt;
  logic [CTX_W-1:0]    act_ctx;
  instr_t              ins;
  logic [DP_WIDTH-1:0] imm_sx, opa, opb, alu, res_nxt;
  logic                alu_wr, exec, load_done, res_wr, conf_rej, conf_ok;

  // the running context is write-protected; all others stay programmable
  assign conf_rej = conf_we_i && busy_o && (conf_wctx_i == act_ctx);
  assign conf_ok  = conf_we_i && !conf_rej;

  rc_ctx_conf_regs #(
    .N_CTX (N_CTX),
    .N_CREG(N_CREG),
    .CTX_W (CTX_W),
    .PC_W  (PC_W)
  ) u_conf (
    .gclk  (clk_i),
    .grst_n(rst_ni),
    .we    (conf_ok),
    .wctx  (conf_wctx_i),
    .waddr (conf_waddr_i),
    .wdata (instr_t'(conf_wdata_i)),
    .rctx  (act_ctx),
    .raddr (global_pc_i),
    .rdata (ins)
  );

  assign imm_sx = {{(DP_WIDTH-IMM_W){ins.imm[IMM_W-1]}}, ins.imm};

  always_comb begin
    opa = '0;
    opb = '0;
    if (ins.sel_a == '0) opa = result_o;
    if (ins.sel_b == '0) opb = result_o;
    for (int k = 0; k < N_NEIGH; k++) begin
      if (int'(ins.sel_a) == k + 1) opa = neigh_res_i[k*DP_WIDTH +: DP_WIDTH];
      if (int'(ins.sel_b) == k + 1) opb = neigh_res_i[k*DP_WIDTH +: DP_WIDTH];
    end
    if (int'(ins.sel_a) == N_NEIGH + 1) opa = imm_sx;
    if (int'(ins.sel_b) == N_NEIGH + 1) opb = imm_sx;
  end

  always_comb begin
    alu    = result_o;
    alu_wr = 1'b0;
    case (ins.op)
      OP_ADD: begin alu = opa + opb;                alu_wr = 1'b1; end
      OP_SUB: begin alu = opa - opb;                alu_wr = 1'b1; end
      OP_AND: begin alu = opa & opb;                alu_wr = 1'b1; end
      OP_OR:  begin alu = opa | opb;                alu_wr = 1'b1; end
      OP_XOR: begin alu = opa ^ opb;                alu_wr = 1'b1; end
      OP_SLL: begin alu = opa << opb[SH_W-1:0];     alu_wr = 1'b1; end
      OP_SRL: begin alu = opa >> opb[SH_W-1:0];     alu_wr = 1'b1; end
      default: ;
    endcase
  end

  assign exec      = (state == S_RUN) && pc_en_i;
  assign load_done = !data_wen_o && data_rvalid_i &&
                     (((state == S_MEM_REQ) && data_gnt_i) || (state == S_MEM_WAIT));
  assign res_wr    = (exec && alu_wr) || load_done;
  assign res_nxt   = load_done ? data_rdata_i : alu;

  always_comb begin
    state_nxt  = state;
    busy_o     = 1'b1;
    rc_stall_o = 1'b0;
    data_req_o = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (pc_en_i) begin
          if (ins.op == OP_LOAD || ins.op == OP_STORE) state_nxt = S_MEM_REQ;
          else if (ins.op == OP_EXIT)                  state_nxt = S_IDLE;
        end
      end
      S_MEM_REQ: begin
        rc_stall_o = 1'b1;
        data_req_o = 1'b1;
        if (data_gnt_i) state_nxt = (data_wen_o || data_rvalid_i) ? S_RUN : S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        rc_stall_o = 1'b1;
        if (data_rvalid_i) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_ctx      <= '0;
      result_o     <= '0;
      flag_o       <= '0;
      br_req_o     <= 1'b0;
      br_add_o     <= '0;
      data_wen_o   <= 1'b0;
      data_add_o   <= '0;
      data_wdata_o <= '0;
      conf_err_o   <= 1'b0;
      exec_end_o   <= 1'b0;
    end else begin
      br_req_o   <= 1'b0;
      exec_end_o <= 1'b0;
      conf_err_o <= conf_rej;
      if (state == S_IDLE && start_i) act_ctx <= ctx_sel_i;
      if (res_wr) begin
        result_o <= res_nxt;
        flag_o   <= {res_nxt[DP_WIDTH-1], res_nxt == '0};
      end
      // address/data are captured at issue so they stay stable until grant
      if (exec) begin
        case (ins.op)
          OP_LOAD: begin
            data_add_o   <= opa + opb;
            data_wdata_o <= '0;
            data_wen_o   <= 1'b0;
          end
          OP_STORE: begin
            data_add_o   <= opa;
            data_wdata_o <= opb;
            data_wen_o   <= 1'b1;
          end
          OP_BRZ: begin
            if (opa == '0) begin
              br_req_o <= 1'b1;
              br_add_o <= ins.imm[PC_W-1:0];
            end
          end
          OP_EXIT: exec_end_o <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reconfigurable_cell_mc.sv
// Directed + randomized bench for reconfigurable_cell_mc with a behavioural
// model of operand selection, ALU and memory handshake timing.
module tb_reconfigurable_cell_mc;
  import cgra_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               conf_we_i;
  logic [0:0]         conf_wctx_i;
  logic [3:0]         conf_waddr_i;
  logic [INSTR_W-1:0] conf_wdata_i;
  logic [0:0]         ctx_sel_i;
  logic               start_i, pc_en_i;
  logic [3:0]         global_pc_i;
  logic [127:0]       neigh_res_i;
  logic               data_gnt_i, data_rvalid_i;
  logic [31:0]        data_rdata_i;
  logic [31:0]        result_o, data_add_o, data_wdata_o;
  logic [1:0]         flag_o;
  logic [3:0]         br_add_o;
  logic               br_req_o, data_req_o, data_wen_o, rc_stall_o, busy_o;
  logic               conf_err_o, exec_end_o;

  logic [31:0] nb [4];
  logic [31:0] mdl_res;
  logic [1:0]  mdl_flag;
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  int          r_op [8], r_sa [8], r_sb [8], r_imm [8];
  int          cyc;

  assign neigh_res_i = {nb[3], nb[2], nb[1], nb[0]};

  always #5 clk_i = ~clk_i;

  reconfigurable_cell_mc dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .conf_we_i(conf_we_i), .conf_wctx_i(conf_wctx_i),
    .conf_waddr_i(conf_waddr_i), .conf_wdata_i(conf_wdata_i), .ctx_sel_i(ctx_sel_i),
    .start_i(start_i), .pc_en_i(pc_en_i), .global_pc_i(global_pc_i),
    .neigh_res_i(neigh_res_i), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .result_o(result_o), .flag_o(flag_o),
    .br_req_o(br_req_o), .br_add_o(br_add_o), .data_req_o(data_req_o),
    .data_wen_o(data_wen_o), .data_add_o(data_add_o), .data_wdata_o(data_wdata_o),
    .rc_stall_o(rc_stall_o), .busy_o(busy_o), .conf_err_o(conf_err_o),
    .exec_end_o(exec_end_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [INSTR_W-1:0] mk(input int op, input int sa, input int sb, input int imm);
    logic [3:0]       o = op[3:0];
    logic [SEL_W-1:0] a = sa[SEL_W-1:0];
    logic [SEL_W-1:0] b = sb[SEL_W-1:0];
    logic [15:0]      i = imm[15:0];
    return {o, a, b, i};
  endfunction

  // operand value as the selector rules define it: 0 result, 1..4 neighbour,
  // 5 sign-extended immediate, anything else zero
  function automatic logic [31:0] m_opnd(input int sel, input int imm);
    if (sel == 0) return mdl_res;
    if (sel >= 1 && sel <= 4) return nb[sel-1];
    if (sel == 5) return 32'(signed'(16'(imm)));
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh = b[4:0];
    case (op)
      1: return a + b;
      2: return a - b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return a << sh;
      7: return a >> sh;
      default: return mdl_res;
    endcase
  endfunction

  task automatic cfg(input int ctx, input int slot, input logic [INSTR_W-1:0] w);
    conf_we_i    = 1'b1;
    conf_wctx_i  = ctx[0:0];
    conf_waddr_i = slot[3:0];
    conf_wdata_i = w;
    step();
    conf_we_i    = 1'b0;
  endtask

  task automatic exec(input int pc);
    pc_en_i     = 1'b1;
    global_pc_i = pc[3:0];
    step();
    pc_en_i     = 1'b0;
  endtask

  // g = cycle (1-based, counted from first stall cycle) carrying grant,
  // r = further cycles until rvalid (0 = same cycle as grant)
  task automatic mem_op(input int g, input int r, input logic [31:0] rd,
                        input logic [31:0] addr, output int n);
    n = 0;
    while (rc_stall_o && n < 40) begin
      n++;
      chk("mem_req_level", data_req_o, (n <= g) ? 32'd1 : 32'd0);
      chk("mem_addr_hold", data_add_o, addr);
      data_gnt_i    = (n == g);
      data_rvalid_i = (n == g + r);
      data_rdata_i  = rd;
      step();
    end
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; conf_we_i = 1'b0; conf_wctx_i = '0; conf_waddr_i = '0; conf_wdata_i = '0;
    ctx_sel_i = '0; start_i = 1'b0; pc_en_i = 1'b0; global_pc_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    for (int k = 0; k < 4; k++) nb[k] = '0;
    mdl_res = '0; mdl_flag = '0;
    step(); step();
    chk("rst_result", result_o, 32'd0);
    chk("rst_ctrl", {flag_o, br_req_o, data_req_o, data_wen_o, rc_stall_o, busy_o,
                     conf_err_o, exec_end_o}, 32'd0);
    chk("rst_bus", data_add_o | data_wdata_o | 32'(br_add_o), 32'd0);
    rst_ni = 1'b1;
    step();

    cfg(0, 0, mk(OP_ADD, 5, 1, 5));
    cfg(0, 1, mk(OP_SUB, 1, 2, 0));
    cfg(0, 2, mk(OP_LOAD, 1, 2, 0));
    cfg(0, 3, mk(OP_SUB, 5, 6, 7));
    cfg(0, 4, mk(OP_BRZ, 3, 6, 9));
    cfg(0, 5, mk(OP_STORE, 1, 2, 0));
    cfg(0, 6, mk(OP_EXIT, 0, 0, 0));
    for (int s = 0; s < 8; s++) begin
      r_op[s] = $urandom_range(0, 15);
      if (r_op[s] >= 8 && r_op[s] <= 11) r_op[s] += 4;
      r_sa[s]  = $urandom_range(0, 7);
      r_sb[s]  = $urandom_range(0, 7);
      r_imm[s] = $urandom_range(0, 65535);
      cfg(0, 8 + s, mk(r_op[s], r_sa[s], r_sb[s], r_imm[s]));
    end
    chk("idle_no_err", conf_err_o, 32'd0);
    exec(0);
    chk("idle_pc_ignored", result_o, 32'd0);
    ctx_sel_i = 1'd0; start_i = 1'b1; step(); start_i = 1'b0;
    chk("start_busy", busy_o, 32'd1);

    nb[0] = 32'd7;
    exec(0);
    chk("add_result", result_o, 32'd12);
    chk("add_flag", flag_o, 32'd0);
    nb[0] = 32'd3; nb[1] = 32'd5;
    exec(1);
    chk("sub_neg_result", result_o, 32'hFFFF_FFFE);
    chk("sub_neg_flag", flag_o, 32'd2);
    nb[0] = 32'd4; nb[1] = 32'd4;
    exec(1);
    chk("sub_zero_result", result_o, 32'd0);
    chk("sub_zero_flag", flag_o, 32'd1);
    mdl_res = 32'd0; mdl_flag = 2'b01;

    for (int i = 0; i < 60; i++) begin
      int s;
      logic en;
      for (int k = 0; k < 4; k++) nb[k] = $urandom;
      if (i % 7 == 0) nb[$urandom_range(0, 3)] = 32'd0;
      s  = $urandom_range(0, 7);
      en = ($urandom_range(0, 3) != 0);
      if (en && r_op[s] >= 1 && r_op[s] <= 7) begin
        mdl_res  = m_alu(r_op[s], m_opnd(r_sa[s], r_imm[s]), m_opnd(r_sb[s], r_imm[s]));
        mdl_flag = {mdl_res[31], mdl_res == 32'd0};
      end
      pc_en_i = en; global_pc_i = 4'(8 + s);
      step();
      pc_en_i = 1'b0;
      chk("rand_result", result_o, mdl_res);
      chk("rand_flag", flag_o, 32'(mdl_flag));
    end

    nb[0] = 32'h100; nb[1] = 32'h20;
    pc_en_i = 1'b1; global_pc_i = 4'd2;
    step();
    global_pc_i = 4'd0;
    chk("ld_req", data_req_o, 32'd1);
    chk("ld_wen", data_wen_o, 32'd0);
    mem_op(3, 2, 32'hCAFE, 32'h120, cyc);
    pc_en_i = 1'b0;
    chk("ld_stall_cycles", cyc, 32'd5);
    chk("ld_result", result_o, 32'hCAFE);
    chk("ld_flag", flag_o, 32'd0);
    mdl_res = 32'hCAFE;

    for (int i = 0; i < 4; i++) begin
      int g, r;
      logic [31:0] rd;
      g = $urandom_range(1, 4); r = (i == 0) ? 0 : $urandom_range(0, 3); rd = $urandom;
      nb[0] = $urandom; nb[1] = $urandom;
      pc_en_i = 1'b1; global_pc_i = 4'd2;
      step();
      global_pc_i = 4'd0;
      mem_op(g, r, rd, nb[0] + nb[1], cyc);
      pc_en_i = 1'b0;
      chk("rld_stall_cycles", cyc, g + r);
      chk("rld_result", result_o, rd);
      mdl_res = rd;
    end

    nb[0] = 32'h40; nb[1] = 32'hDEAD;
    exec(5);
    chk("st_wen", data_wen_o, 32'd1);
    chk("st_wdata", data_wdata_o, 32'hDEAD);
    mem_op(2, 0, 32'h1234, 32'h40, cyc);
    chk("st_stall_cycles", cyc, 32'd2);
    chk("st_result_kept", result_o, mdl_res);

    nb[2] = 32'd0;
    exec(4);
    chk("brz_req", br_req_o, 32'd1);
    chk("brz_add", br_add_o, 32'd9);
    chk("brz_result_kept", result_o, mdl_res);
    step();
    chk("brz_pulse_end", br_req_o, 32'd0);
    nb[2] = 32'd1;
    exec(4);
    chk("brz_not_taken", br_req_o, 32'd0);

    cfg(1, 3, mk(OP_ADD, 5, 6, 100));
    chk("cfg_inactive_ok", conf_err_o, 32'd0);
    cfg(1, 6, mk(OP_EXIT, 0, 0, 0));
    cfg(1, 2, mk(OP_LOAD, 1, 2, 0));
    cfg(0, 3, mk(OP_ADD, 5, 6, 55));
    chk("cfg_active_err", conf_err_o, 32'd1);
    step();
    chk("cfg_err_pulse_end", conf_err_o, 32'd0);
    exec(3);
    chk("cfg_dropped", result_o, 32'd7);
    exec(6);
    chk("exit_pulse", exec_end_o, 32'd1);
    chk("exit_busy", busy_o, 32'd0);
    step();
    chk("exit_pulse_end", exec_end_o, 32'd0);
    ctx_sel_i = 1'd1; start_i = 1'b1; step(); start_i = 1'b0;
    exec(3);
    chk("ctx1_new_slot", result_o, 32'd100);
    ctx_sel_i = 1'd0; start_i = 1'b1; step(); start_i = 1'b0;
    exec(3);
    chk("start_while_busy", result_o, 32'd100);
    cfg(1, 9, mk(OP_ADD, 5, 6, 1));
    chk("cfg_active_err_ctx1", conf_err_o, 32'd1);

    nb[0] = 32'h10; nb[1] = 32'h20;
    exec(2);
    data_gnt_i = 1'b1; step(); data_gnt_i = 1'b0;
    chk("rst_pre_wait_stall", rc_stall_o, 32'd1);
    chk("rst_pre_wait_req", data_req_o, 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("rst_async_ctrl", {data_req_o, rc_stall_o, busy_o}, 32'd0);
    chk("rst_async_result", result_o, 32'd0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD;
    step();
    rst_ni = 1'b1;
    step(); step();
    data_rvalid_i = 1'b0;
    chk("rst_no_stale_load", result_o, 32'd0);
    chk("rst_post_ctrl", {rc_stall_o, busy_o}, 32'd0);
    ctx_sel_i = 1'd0; start_i = 1'b1; step(); start_i = 1'b0;
    nb[0] = 32'd7;
    exec(0);
    chk("cfg_reset_nop", {30'd0, flag_o} | result_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reconfigurable_cell_mc.md
RECONFIGURABLE_CELL_MC -- requirements
Module: reconfigurable_cell_mc

Interface
REQ-001 Parameters SHALL be: DP_WIDTH, 32, datapath width; N_NEIGH, 4, neighbour result inputs; N_CREG, 16, instruction slots per context; N_CTX, 2, configuration contexts.
REQ-002 Ports SHALL be (name  direction  width  meaning):
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
conf_we_i  in  1  configuration write strobe
conf_wctx_i  in  clog2(N_CTX)  context written
conf_waddr_i  in  clog2(N_CREG)  slot written
conf_wdata_i  in  INSTR_W  instruction written
ctx_sel_i  in  clog2(N_CTX)  context to execute, sampled on start_i
start_i  in  1  begin kernel
pc_en_i  in  1  execute slot at global_pc_i this cycle
global_pc_i  in  clog2(N_CREG)  array program counter
neigh_res_i  in  N_NEIGH*DP_WIDTH  neighbour results
data_gnt_i  in  1  memory grant
data_rvalid_i  in  1  load data valid
data_rdata_i  in  DP_WIDTH  load data
result_o  out  DP_WIDTH  registered result
flag_o  out  2  {neg, zero} of result_o
br_req_o  out  1  branch request pulse
br_add_o  out  clog2(N_CREG)  branch target
data_req_o  out  1  memory request
data_wen_o  out  1  1 = store
data_add_o  out  DP_WIDTH  address
data_wdata_o  out  DP_WIDTH  store data
rc_stall_o  out  1  memory op outstanding
busy_o  out  1  kernel running
conf_err_o  out  1  one-cycle pulse: write to active context rejected
exec_end_o  out  1  one-cycle pulse on EXIT

Function
REQ-003 Instruction fields SHALL be op[3:0], sel_a, sel_b (SEL_W = clog2(N_NEIGH+3)), imm[IMM_W=16].
REQ-004 Operand select SHALL map 0 = result_o, 1..N_NEIGH = neighbour k-1, N_NEIGH+1 = sign-extended imm, N_NEIGH+2 = zero; out-of-range values SHALL select zero.
REQ-005 Ops SHALL be NOP, ADD, SUB, AND, OR, XOR, SLL, SRL (shift by B[clog2(DP_WIDTH)-1:0]), LOAD (addr A+B), STORE (addr A, data B), BRZ, EXIT; undefined opcodes SHALL execute as NOP.
REQ-006 Arithmetic SHALL wrap modulo 2^DP_WIDTH; flag_o SHALL update whenever result_o updates.
REQ-007 Controller states SHALL be IDLE, RUN, MEM_REQ, MEM_WAIT.
REQ-008 IDLE + start_i: latch ctx_sel_i as active context, go to RUN, busy_o = 1.
REQ-009 RUN + pc_en_i: fetch slot global_pc_i of active context; ALU ops write result_o exactly one cycle later.
REQ-010 LOAD/STORE SHALL enter MEM_REQ: data_req_o held with stable address/data until data_gnt_i; STORE then returns to RUN; LOAD goes to MEM_WAIT until data_rvalid_i, captures data_rdata_i into result_o, returns to RUN.
REQ-011 rc_stall_o SHALL be high in MEM_REQ and MEM_WAIT; pc_en_i SHALL be ignored while rc_stall_o is high.
REQ-012 Grant and rvalid in the same cycle SHALL complete the load in that cycle.
REQ-013 BRZ SHALL pulse br_req_o with br_add_o = imm[clog2(N_CREG)-1:0] when operand A is zero; result_o unchanged.
REQ-014 EXIT SHALL pulse exec_end_o, clear busy_o, return to IDLE.
REQ-015 Configuration writes to inactive contexts SHALL be accepted in any state; a write to the active context while busy_o SHALL be dropped and pulse conf_err_o.
REQ-016 start_i while busy_o SHALL be ignored.

Reset
REQ-017 Asserting rst_ni SHALL immediately force IDLE and all outputs to 0; configuration storage SHALL reset to NOP; reset mid-memory-op SHALL drop data_req_o without waiting for grant.

Structure
REQ-018 Opcode enum, instruction struct, SEL_W, IMM_W, INSTR_W SHALL live in cgra_pkg.
REQ-019 Context storage SHALL be sub-module rc_ctx_conf_regs (N_CTX x N_CREG, one write port, one combinational read port).

Verification
REQ-020 ADD sel_a=imm 5, sel_b=neigh0=7 at pc 0 -> result_o=12, flag_o=00 next cycle.
REQ-021 SUB 3-5 -> result_o=0xFFFFFFFE, flag_o=10; SUB 4-4 -> flag_o=01.
REQ-022 LOAD, grant after 3 cycles, rvalid 2 later with 0xCAFE -> rc_stall_o high 5 cycles, result_o=0xCAFE, pc_en_i ignored meanwhile.
REQ-023 Run context 0, write context 1 slot 3 then context 0 slot 3 -> first accepted, second dropped with conf_err_o pulse; EXIT then start ctx 1 executes new slot 3.
REQ-024 BRZ A=0 imm=9 -> br_req_o one cycle, br_add_o=9; A=1 -> no request.
REQ-025 rst_ni low during MEM_WAIT -> data_req_o, rc_stall_o, busy_o 0 immediately; no stale load capture after release.
